dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters. Port 0 is the processor's memory-stage access path. Port 1 is a secondary master (image loader/streamer).
- Sits outside the processor, between both masters and the data memory.
- Runs one transaction at a time through an FSM: latch request, drive memory, wait read latency, acknowledge.
- Port 0 has fixed priority; a starvation counter guarantees port 1 forward progress.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 32, address width.
- READ_LAT, 1, data-memory read latency in cycles (>=1).
- MAX_WAIT, 4, consecutive port-0 grants tolerated while port 1 is pending before port 1 is forced.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held until p0_ack
- p0_we  in  1  port 0 write enable (1 = write, 0 = read)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_rdata  out  DATA_W  port 0 read data, registered
- p0_ack  out  1  port 0 one-cycle completion pulse
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ack  same as port 0, for port 1
- mem_we  out  1  data-memory write enable
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_rdata  in  DATA_W  data-memory read data, valid READ_LAT cycles after mem_addr
- grant  out  2  one-hot owner ({p1,p0}); 00 when idle

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state IDLE; all outputs 0 (rdata, ack, mem_*, grant); starvation counter 0; latched request registers 0.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE, arbitration:
  - No request: stay in IDLE.
  - Winner is p1 if p1_req and (!p0_req or starve_cnt == MAX_WAIT); otherwise p0 if p0_req.
  - On a grant, latch the winner's we/addr/wdata and owner, then go to ACCESS.
  - After latching, requester inputs are ignored until ack.
- Starvation counter:
  - Increments on each p0 grant made while p1_req = 1, saturating at MAX_WAIT.
  - Clears on any p1 grant, and in IDLE whenever p1_req = 0.
- ACCESS (1 cycle):
  - mem_addr/mem_wdata driven from latched values.
  - mem_we = latched we.
  - Write: next state DONE. Read: next state WAIT.
- WAIT (READ_LAT cycles, internal counter):
  - mem_we = 0; mem_addr held.
  - At the end of the last WAIT cycle, capture mem_rdata into the owner's pN_rdata, then go to DONE.
- DONE (1 cycle):
  - Owner's pN_ack = 1 (registered, exactly one cycle).
  - pN_rdata valid and stable.
  - Next state IDLE.
  - The requester may drop or re-raise req; req is re-sampled only in IDLE.
- Latency:
  - Write: grant edge to ack = 2 cycles; 3-cycle occupancy.
  - Read: 2 + READ_LAT cycles to ack.
- grant = owner one-hot during ACCESS/WAIT/DONE, 00 in IDLE.
- mem_we is high only in ACCESS for writes; never in any other state.
- mem_addr/mem_wdata hold their last value outside ACCESS/WAIT.
- pN_rdata holds until that port's next read completes; writes never modify it.
- Non-owner ack and rdata are unaffected by the other port's transaction.
- Simultaneous p0_req and p1_req: p0 wins unless starve_cnt == MAX_WAIT.
- Request dropped before ack (protocol violation): the transaction completes and ack still pulses.
- Reset mid-transaction: abort immediately; no ack issued; a write already in ACCESS is not retried.

Test Plan:
- Reset then idle, both req = 0 -> grant = 00, mem_we = 0, all ack = 0 for 10 cycles.
- p0 write addr 0x10 data 0xDEADBEEF at cycle t:
  - mem_we = 1 and mem_addr = 0x10 at t+1 only.
  - p0_ack at t+2.
  - grant = 01 in t+1..t+2.
- Port 1 reads back (READ_LAT = 1), memory model returns 0xDEADBEEF:
  - p1_ack at t+3.
  - p1_rdata = 0xDEADBEEF.
  - p0_rdata unchanged.
- Both req held continuously with MAX_WAIT = 4 -> grant order p0,p0,p0,p0,p1,p0,p0,p0,p0,p1.
- p0 request with its address changed to 0x20 in the cycle after grant -> memory access still uses the original 0x10.
- rst asserted during WAIT of a read:
  - All outputs 0 asynchronously; no ack.
  - After release, a new p0 read completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the processor
// memory stage (port 0) and a secondary streaming master (port 1).
// One transaction at a time. Port 0 has fixed priority, and a starvation
// counter forces a port 1 grant after MAX_WAIT consecutive port 0 grants
// made while port 1 was waiting.
//
// state  | meaning
// IDLE   | no owner; arbitrate and latch the winning request
// ACCESS | drive the memory with the latched request (mem_we only for writes)
// WAIT   | read in flight; count READ_LAT cycles, then capture mem_rdata
// DONE   | pulse the owner's ack for one cycle, then release the memory
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t         state;
    logic           owner;      // 0 = port 0, 1 = port 1
    logic           lat_we;
    logic [SW-1:0]  starve_cnt;
    logic [CW-1:0]  wait_cnt;
    logic           p1_wins;

    // Port 1 wins when port 0 is quiet or port 1 has waited long enough
    assign p1_wins = p1_req && (!p0_req || (starve_cnt == SW'(MAX_WAIT)));

    // Transaction FSM; every output is registered here. The latched address
    // and write data live directly in mem_addr/mem_wdata, which hold until
    // the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (p1_wins) begin
                        owner      <= 1'b1;
                        lat_we     <= p1_we;
                        mem_we     <= p1_we;
                        mem_addr   <= p1_addr;
                        mem_wdata  <= p1_wdata;
                        grant      <= 2'b10;
                        starve_cnt <= '0;
                        state      <= ACCESS;
                    end else if (p0_req) begin
                        owner      <= 1'b0;
                        lat_we     <= p0_we;
                        mem_we     <= p0_we;
                        mem_addr   <= p0_addr;
                        mem_wdata  <= p0_wdata;
                        grant      <= 2'b01;
                        if (!p1_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != SW'(MAX_WAIT))
                            starve_cnt <= starve_cnt + 1'b1;
                        state      <= ACCESS;
                    end else if (!p1_req) begin
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (lat_we) begin
                        if (owner) p1_ack <= 1'b1;
                        else       p0_ack <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= CW'(READ_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (owner) begin
                            p1_rdata <= mem_rdata;
                            p1_ack   <= 1'b1;
                        end else begin
                            p0_rdata <= mem_rdata;
                            p0_ack   <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    grant  <= 2'b00;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed transactions with a scoreboard of
// expected acknowledgements checked by an independent monitor, plus
// cycle-exact checks on the memory-side signals.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic        p0_ack, p1_ack, mem_we;
    logic [1:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          port;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(1), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    // Single-port memory, one cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    function automatic exp_t mk(bit port, bit chk, logic [31:0] data);
        exp_t e;
        e.port = port;
        e.chk  = chk;
        e.data = data;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_ack(bit port);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: port %0d acked with nothing expected", port);
        end else begin
            e = sb.pop_front();
            chk("ack_port", {31'd0, port}, {31'd0, e.port});
            if (e.chk) chk("ack_rdata", port ? p1_rdata : p0_rdata, e.data);
        end
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented
    always @(negedge clk) begin
        if (!rst) begin
            if (p0_ack) check_ack(1'b0);
            if (p1_ack) check_ack(1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(bit port, bit we, logic [31:0] addr, logic [31:0] wdata);
        if (port) begin
            p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(); tick();
        rst = 0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outputs", {28'd0, grant, mem_we, p0_ack, p1_ack}, 32'd0);
        end
        chk("reset_p0_rdata", p0_rdata, 32'd0);
        chk("reset_p1_rdata", p1_rdata, 32'd0);

        // p0 write 0x10 <- DEADBEEF, cycle-exact
        sb.push_back(mk(0, 0, 0));
        start(0, 1, 32'h10, 32'hDEADBEEF);
        tick();
        chk("wr_t1_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_t1_mem_addr", mem_addr, 32'h10);
        chk("wr_t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_t1_grant", {30'd0, grant}, 32'd1);
        chk("wr_t1_ack", {31'd0, p0_ack}, 32'd0);
        tick();
        chk("wr_t2_ack", {31'd0, p0_ack}, 32'd1);
        chk("wr_t2_mem_we", {31'd0, mem_we}, 32'd0);
        chk("wr_t2_grant", {30'd0, grant}, 32'd1);
        p0_req = 0;
        tick();
        chk("wr_t3_grant", {30'd0, grant}, 32'd0);
        chk("wr_t3_p0_rdata", p0_rdata, 32'd0);

        // p1 write 0x20 <- CAFEF00D
        sb.push_back(mk(1, 0, 0));
        start(1, 1, 32'h20, 32'hCAFEF00D);
        tick(); tick();
        p1_req = 0;
        tick();

        // p1 reads back 0x10
        sb.push_back(mk(1, 1, 32'hDEADBEEF));
        start(1, 0, 32'h10, 32'h0);
        tick();
        chk("rd_t1_grant", {30'd0, grant}, 32'd2);
        chk("rd_t1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_t1_mem_addr", mem_addr, 32'h10);
        tick();
        chk("rd_t2_ack", {31'd0, p1_ack}, 32'd0);
        tick();
        chk("rd_t3_ack", {31'd0, p1_ack}, 32'd1);
        chk("rd_t3_p1_rdata", p1_rdata, 32'hDEADBEEF);
        chk("rd_t3_p0_rdata", p0_rdata, 32'd0);
        chk("rd_t3_p0_ack", {31'd0, p0_ack}, 32'd0);
        p1_req = 0;
        tick();

        // Both requesting continuously: starvation guard lets p1 in every 5th
        for (int i = 0; i < 10; i++) sb.push_back(mk((i % 5) == 4, 0, 0));
        start(0, 1, 32'h40, 32'h11111111);
        start(1, 1, 32'h44, 32'h22222222);
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick();
            if (p0_ack || p1_ack) n++;
        end
        p0_req = 0;
        p1_req = 0;
        chk("arb_ack_count", n, 10);
        tick();

        // Address changes after grant are ignored
        sb.push_back(mk(0, 1, 32'hDEADBEEF));
        start(0, 0, 32'h10, 32'h0);
        tick();
        p0_addr = 32'h20;
        chk("latch_t1_mem_addr", mem_addr, 32'h10);
        tick();
        chk("latch_t2_mem_addr", mem_addr, 32'h10);
        tick();
        chk("latch_t3_ack", {31'd0, p0_ack}, 32'd1);
        p0_req = 0;
        tick();

        // Reset during WAIT of a read aborts without ack
        start(0, 0, 32'h20, 32'h0);
        tick(); tick();
        rst = 1;
        #1;
        chk("rst_ctrl_outputs", {28'd0, grant, mem_we, p0_ack, p1_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        p0_req = 0;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", {28'd0, grant, mem_we, p0_ack, p1_ack}, 32'd0);
        end

        // New read after reset completes normally
        sb.push_back(mk(0, 1, 32'hCAFEF00D));
        start(0, 0, 32'h20, 32'h0);
        tick(); tick(); tick();
        chk("post_rst_ack", {31'd0, p0_ack}, 32'd1);
        chk("post_rst_rdata", p0_rdata, 32'hCAFEF00D);
        p0_req = 0;
        tick(); tick(); tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
